// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: sequencer for an external 1-bit ALU slice.
// Accepts a WIDTH-bit operation, presents one operand bit per clock to the
// slice LSB-first, feeds the slice carry-out back as the next carry-in and
// assembles the result plus {N,Z,C,V} flags.
// Optional feature macro: BITSER_FLAGS_EN (flags computed when defined,
// tied to 4'b0000 otherwise; result and timing are identical either way).
module bit_serial_alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             slice_A,
    output logic             slice_B,
    output logic             slice_CI,
    output logic [2:0]       slice_S,
    input  logic             slice_out,
    input  logic             slice_CO,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             err_q;
    logic [2:0]       op_q;

    // Legal opcodes: passB, add, sub, and, or, xor.
    function automatic logic op_legal(input logic [2:0] o);
        return (o != 3'b001) && (o != 3'b111);
    endfunction

    // Add and sub are the only ops whose carry chain is meaningful.
    function automatic logic op_arith(input logic [2:0] o);
        return (o == 3'b010) || (o == 3'b011);
    endfunction

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign err      = done & err_q;
    assign slice_A  = busy & a_sh[0];
    assign slice_B  = busy & b_sh[0];
    assign slice_CI = busy & carry;
    assign slice_S  = op_q;

`ifdef BITSER_FLAGS_EN
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] res_full;
    logic [3:0]       flags_next;

    // Result as it will stand once the MSB from the slice is written in; the
    // MSB of the result register is still zero at that point (cleared on start).
    always_comb begin
        res_full             = result;
        res_full[WIDTH-1]    = slice_out;
        flags_next[3]        = slice_out;
        flags_next[2]        = (res_full == '0);
        flags_next[1]        = op_arith(op_q) & slice_CO;
        flags_next[0]        = op_arith(op_q) & (carry ^ slice_CO);
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

    // Main FSM: capture on start, shift one bit per RUN cycle, pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            err_q  <= 1'b0;
            op_q   <= 3'b000;
            result <= '0;
`ifdef BITSER_FLAGS_EN
            flags_q <= 4'b0000;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_sh   <= a;
                        b_sh   <= b;
                        cnt    <= '0;
                        result <= '0;
                        // Sub relies on the slice inverting B plus a carry-in of 1.
                        carry  <= op_arith(op) & op[0];
                        err_q  <= ~op_legal(op);
                        state  <= op_legal(op) ? S_RUN : S_DONE;
`ifdef BITSER_FLAGS_EN
                        flags_q <= 4'b0000;
`endif
                    end
                end
                S_RUN: begin
                    a_sh        <= a_sh >> 1;
                    b_sh        <= b_sh >> 1;
                    result[cnt] <= slice_out;
                    carry       <= slice_CO;
                    cnt         <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
`ifdef BITSER_FLAGS_EN
                        flags_q <= flags_next;
`endif
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
